// File: rtl/mem_access_sequencer_pkg.sv
// Shared definitions for the data-memory access sequencer: access size
// encodings, sequencer state encoding, controller opcodes and the
// alignment predicate used when MEM_MISALIGN_TRAP_EN is defined.
package mem_access_sequencer_pkg;

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        WAIT  = 3'd3,
        MERGE = 3'd4,
        DONE  = 3'd5
    } seqState_t;

    // Primary opcodes the main controller decodes into MemRead/MemWrite
    // and Load_size/Store_size.
    localparam logic [5:0] OP_LW = 6'h23;
    localparam logic [5:0] OP_LH = 6'h21;
    localparam logic [5:0] OP_LB = 6'h20;
    localparam logic [5:0] OP_SW = 6'h2b;
    localparam logic [5:0] OP_SH = 6'h29;
    localparam logic [5:0] OP_SB = 6'h28;

    // Size code 2'b11 behaves like a word access everywhere.
    function automatic logic isWordSize(input logic [1:0] size);
        return (size != SIZE_HALF) && (size != SIZE_BYTE);
    endfunction

    // True when the low address bits do not suit the access size.
    function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] lane);
        logic bad;
        case (size)
            SIZE_HALF: bad = lane[0];
            SIZE_BYTE: bad = 1'b0;
            default:   bad = (lane != 2'b00);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_sequencer_lane.sv
// mem_lane_merge: combinational lane logic for sub-word accesses.
// Produces the store word with the selected byte/half lane replaced and
// the sign-extended load value extracted from the selected lane.
module mem_lane_merge
    import mem_access_sequencer_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] data,
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    output logic [31:0] merged,
    output logic [31:0] loadVal
);

    logic [7:0]  selByte;
    logic [15:0] selHalf;

    // Lane selection and replacement; word accesses pass straight through.
    always_comb begin
        merged  = word;
        loadVal = word;
        selByte = word[8*lane +: 8];
        selHalf = word[16*lane[1] +: 16];
        case (size)
            SIZE_BYTE: begin
                merged[8*lane +: 8] = data[7:0];
                loadVal = {{24{selByte[7]}}, selByte};
            end
            SIZE_HALF: begin
                merged[16*lane[1] +: 16] = data[15:0];
                loadVal = {{16{selHalf[15]}}, selHalf};
            end
            default: begin
                merged  = data;
                loadVal = word;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer: multi-cycle sequencer between the MEM stage and a
// single-port synchronous word memory. Sub-word stores are done as
// read-modify-write. Optional alignment trap: MEM_MISALIGN_TRAP_EN.
module mem_access_sequencer
    import mem_access_sequencer_pkg::*;
#(
    parameter int MEM_AW = 10
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [1:0]        Load_size,
    input  logic [1:0]        Store_size,
    input  logic [31:0]       Address,
    input  logic [31:0]       WriteData,
    output logic              Stall,
    output logic              Done,
    output logic [31:0]       ReadData,
    output logic              Misalign,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    seqState_t         state_q;
    logic              isStore_q;
    logic [1:0]        size_q;
    logic [1:0]        lane_q;
    logic [31:0]       data_q;
    logic [MEM_AW-1:0] memAddr_q;
    logic              memRe_q;
    logic              memWe_q;
    logic [31:0]       memWdata_q;
    logic              done_q;
    logic [31:0]       readData_q;

    logic              request;
    logic [1:0]        reqSize;
    logic              trapHit;
    logic [31:0]       mergedWord;
    logic [31:0]       loadWord;
    logic              unusedAddrHigh;

    // Address bits above the memory span wrap around and are dropped.
    assign unusedAddrHigh = ^Address[31:MEM_AW+2];

    // Store wins over load when both are requested.
    assign request = MemRead || MemWrite;
    assign reqSize = MemWrite ? Store_size : Load_size;

`ifdef MEM_MISALIGN_TRAP_EN
    logic misalign_q;
    assign trapHit  = isMisaligned(reqSize, Address[1:0]);
    assign Misalign = misalign_q;
`else
    assign trapHit  = 1'b0;
    assign Misalign = 1'b0;
`endif

    // The captured memory word is merged/extracted directly on the WAIT edge.
    mem_lane_merge u_lane (
        .word    (mem_rdata),
        .data    (data_q),
        .size    (size_q),
        .lane    (lane_q),
        .merged  (mergedWord),
        .loadVal (loadWord)
    );

    // Stall is combinational so the request cycle itself already holds the pipe.
    assign Stall = ((state_q == IDLE) && request) ||
                   ((state_q != IDLE) && (state_q != DONE));

    assign Done      = done_q;
    assign ReadData  = readData_q;
    assign mem_addr  = memAddr_q;
    assign mem_re    = memRe_q;
    assign mem_we    = memWe_q;
    assign mem_wdata = memWdata_q;

    // Sequencer FSM with registered strobes, Done and load result.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= IDLE;
            isStore_q  <= 1'b0;
            size_q     <= SIZE_WORD;
            lane_q     <= 2'b00;
            data_q     <= '0;
            memAddr_q  <= '0;
            memRe_q    <= 1'b0;
            memWe_q    <= 1'b0;
            memWdata_q <= '0;
            done_q     <= 1'b0;
            readData_q <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            memRe_q <= 1'b0;
            memWe_q <= 1'b0;
            done_q  <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (request) begin
                        isStore_q <= MemWrite;
                        size_q    <= reqSize;
                        lane_q    <= Address[1:0];
                        data_q    <= WriteData;
                        memAddr_q <= Address[MEM_AW+1:2];
                        if (trapHit) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
`ifdef MEM_MISALIGN_TRAP_EN
                            misalign_q <= 1'b1;
`endif
                        end else if (MemWrite && isWordSize(reqSize)) begin
                            state_q    <= WRITE;
                            memWe_q    <= 1'b1;
                            memWdata_q <= WriteData;
                        end else begin
                            state_q <= READ;
                            memRe_q <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end
                READ: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (isStore_q) begin
                        state_q    <= MERGE;
                        memWe_q    <= 1'b1;
                        memWdata_q <= mergedWord;
                    end else begin
                        state_q    <= DONE;
                        done_q     <= 1'b1;
                        readData_q <= loadWord;
                    end
                end
                MERGE: begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Testbench for mem_access_sequencer: directed cases then randomized
// traffic checked through a scoreboard fed by a reference model.
module tb_mem_access_sequencer;

    localparam int MEM_AW = 10;
    localparam int DEPTH  = 1 << MEM_AW;

    logic              Clk = 1'b0;
    logic              Rst = 1'b1;
    logic              MemRead = 1'b0;
    logic              MemWrite = 1'b0;
    logic [1:0]        Load_size = 2'b00;
    logic [1:0]        Store_size = 2'b00;
    logic [31:0]       Address = '0;
    logic [31:0]       WriteData = '0;
    logic              Stall;
    logic              Done;
    logic [31:0]       ReadData;
    logic              Misalign;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_re;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata = '0;

    mem_access_sequencer #(.MEM_AW(MEM_AW)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Load_size  (Load_size),
        .Store_size (Store_size),
        .Address    (Address),
        .WriteData  (WriteData),
        .Stall      (Stall),
        .Done       (Done),
        .ReadData   (ReadData),
        .Misalign   (Misalign),
        .mem_addr   (mem_addr),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 Clk = ~Clk;

    // Synchronous single-port memory: read data appears the cycle after mem_re.
    logic [31:0] mem [DEPTH];
    always @(posedge Clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    int cycleCnt = 0;
    always @(posedge Clk) cycleCnt <= cycleCnt + 1;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        logic [31:0] readData;
        bit          mis;
        int          doneCycle;
    } expect_t;
    expect_t sbQueue[$];

    logic [31:0] refMem [DEPTH];
    logic [31:0] lastRead = '0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: every Done pulse is matched against the oldest expectation.
    always @(negedge Clk) begin
        if (!Rst && Done) begin
            if (sbQueue.size() == 0) begin
                checkOutput("unexpectedDone", 32'd1, 32'd0);
            end else begin
                expect_t e;
                e = sbQueue.pop_front();
                checkOutput("doneCycle", cycleCnt, e.doneCycle);
                checkOutput("misalign", {31'd0, Misalign}, {31'd0, e.mis});
                checkOutput("readData", ReadData, e.readData);
            end
        end
    end

    function automatic bit refTrap(input logic [1:0] sz, input logic [31:0] addr);
`ifdef MEM_MISALIGN_TRAP_EN
        if (sz == 2'b01) return addr[0];
        if (sz == 2'b10) return 1'b0;
        return addr[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] refLoad(input logic [31:0] word, input logic [1:0] sz, input logic [31:0] addr);
        logic [31:0] v;
        if (sz == 2'b10) begin
            v = (word >> (8 * addr[1:0])) & 32'hFF;
            if (v >= 32'h80) v = v - 32'h100;
        end else if (sz == 2'b01) begin
            v = (word >> (16 * addr[1])) & 32'hFFFF;
            if (v >= 32'h8000) v = v - 32'h10000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    function automatic logic [31:0] refStore(input logic [31:0] word, input logic [31:0] data,
                                             input logic [1:0] sz, input logic [31:0] addr);
        logic [31:0] mask;
        int sh;
        if (sz == 2'b10) begin
            sh = 8 * addr[1:0];
            mask = 32'hFF << sh;
            return (word & ~mask) | ((data & 32'hFF) << sh);
        end else if (sz == 2'b01) begin
            sh = 16 * addr[1];
            mask = 32'hFFFF << sh;
            return (word & ~mask) | ((data & 32'hFFFF) << sh);
        end
        return data;
    endfunction

    task automatic setWord(input int idx, input logic [31:0] val);
        mem[idx] = val;
        refMem[idx] = val;
    endtask

    // Issue one access, push its expectation, and hold inputs until Stall drops.
    task automatic applyStimulus(input bit wr, input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] wd);
        expect_t e;
        int idx, lat, wantRe, wantWe, stallCnt, reCnt, weCnt, guard;
        bit trap;
        @(negedge Clk);
        idx  = int'(addr[MEM_AW+1:2]);
        trap = refTrap(sz, addr);
        if (trap) begin
            lat = 1; wantRe = 0; wantWe = 0;
        end else if (wr && (sz == 2'b00 || sz == 2'b11)) begin
            lat = 2; wantRe = 0; wantWe = 1;
            refMem[idx] = wd;
        end else if (wr) begin
            lat = 4; wantRe = 1; wantWe = 1;
            refMem[idx] = refStore(refMem[idx], wd, sz, addr);
        end else begin
            lat = 3; wantRe = 1; wantWe = 0;
            lastRead = refLoad(refMem[idx], sz, addr);
        end
        e.readData  = lastRead;
        e.mis       = trap;
        e.doneCycle = cycleCnt + lat;
        sbQueue.push_back(e);
        MemWrite = wr; MemRead = ~wr | ($urandom_range(0, 1) == 1);
        Store_size = sz; Load_size = wr ? 2'(($urandom_range(0, 3))) : sz;
        Address = addr; WriteData = wd;
        stallCnt = 0; reCnt = 0; weCnt = 0; guard = 0;
        #1;
        while (Stall && guard < 20) begin
            stallCnt++;
            if (mem_re) reCnt++;
            if (mem_we) weCnt++;
            guard++;
            @(negedge Clk);
        end
        checkOutput("stallCycles", stallCnt, lat);
        checkOutput("readStrobes", reCnt, wantRe);
        checkOutput("writeStrobes", weCnt, wantWe);
        MemRead = 1'b0; MemWrite = 1'b0;
    endtask

    initial begin
        int diffs;
        for (int i = 0; i < DEPTH; i++) setWord(i, $urandom);
        #12;
        @(negedge Clk);
        checkOutput("rstStall", {31'd0, Stall}, 32'd0);
        checkOutput("rstDone", {31'd0, Done}, 32'd0);
        checkOutput("rstMemRe", {31'd0, mem_re}, 32'd0);
        checkOutput("rstMemWe", {31'd0, mem_we}, 32'd0);
        checkOutput("rstMisalign", {31'd0, Misalign}, 32'd0);
        checkOutput("rstReadData", ReadData, 32'd0);
        checkOutput("rstMemAddr", 32'(mem_addr), 32'd0);
        checkOutput("rstMemWdata", mem_wdata, 32'd0);
        Rst = 1'b0;

        applyStimulus(1'b1, 2'b00, 32'h0000_0008, 32'hDEADBEEF);
        checkOutput("swWord", mem[2], 32'hDEADBEEF);
        setWord(2, 32'h11223344);
        applyStimulus(1'b1, 2'b10, 32'h0000_000A, 32'h0000_00AA);
        #1 checkOutput("sbMerge", mem[2], 32'h11AA3344);
        setWord(2, 32'h8001_7FFF);
        applyStimulus(1'b0, 2'b01, 32'h0000_000A, 32'h0);
        checkOutput("lhHigh", ReadData, 32'hFFFF8001);
        applyStimulus(1'b0, 2'b01, 32'h0000_0008, 32'h0);
        checkOutput("lhLow", ReadData, 32'h00007FFF);
        setWord(0, 32'h0000_0080);
        applyStimulus(1'b0, 2'b10, 32'h0000_0000, 32'h0);
        checkOutput("lbSext", ReadData, 32'hFFFFFF80);
        setWord(1, 32'hCAFE_F00D);
        applyStimulus(1'b0, 2'b00, 32'h0000_0006, 32'h0);

        // Reset during the MERGE write of a half store aborts it.
        begin
            int guard;
            setWord(5, 32'h1357_9BDF);
            @(negedge Clk);
            MemWrite = 1'b1; MemRead = 1'b0; Store_size = 2'b01;
            Address = 32'h0000_0016; WriteData = 32'h0000_BEEF;
            guard = 0;
            #1;
            while (!mem_we && guard < 10) begin
                @(negedge Clk); guard++;
            end
            checkOutput("mergeReached", {31'd0, mem_we}, 32'd1);
            #2 Rst = 1'b1; MemWrite = 1'b0;
            #1 checkOutput("abortMemWe", {31'd0, mem_we}, 32'd0);
            checkOutput("abortStall", {31'd0, Stall}, 32'd0);
            checkOutput("abortReadData", ReadData, 32'd0);
            @(negedge Clk);
            Rst = 1'b0;
            lastRead = '0;
            @(negedge Clk);
            checkOutput("abortMemWord", mem[5], 32'h1357_9BDF);
        end

        for (int n = 0; n < 250; n++) begin
            logic [31:0] a;
            a = $urandom;
            a[MEM_AW+1:2] = MEM_AW'($urandom_range(0, 15));
            applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom);
            repeat ($urandom_range(0, 2)) @(negedge Clk);
        end

        repeat (3) @(negedge Clk);
        checkOutput("queueEmpty", sbQueue.size(), 32'd0);
        diffs = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== refMem[i]) diffs++;
        checkOutput("memImage", diffs, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running, expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/mem_access_sequencer.md
Name: mem_access_sequencer

Overview:
- Multi-cycle sequencer between the pipeline MEM stage and a single-port, word-wide synchronous data memory.
- Executes word, half and byte loads and stores as decoded by the main controller (MemRead, MemWrite, Load_size, Store_size).
- Sub-word stores run as read-modify-write. The pipeline is stalled until the access completes.

Parameters:
- MEM_AW, 10, word-address width of the data memory; memory holds 2^MEM_AW 32-bit words.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Rst  in  1  reset; asynchronous, active-high.
- MemRead  in  1  load request from controller.
- MemWrite  in  1  store request from controller.
- Load_size  in  2  00 word, 01 half, 10 byte, 11 treated as word.
- Store_size  in  2  same encoding as Load_size.
- Address  in  32  byte address from the ALU.
- WriteData  in  32  store data (rt); sub-word data in low bits.
- Stall  out  1  hold the pipeline; combinational.
- Done  out  1  one-cycle pulse when the access completes.
- ReadData  out  32  sign-extended load result; valid while Done=1, holds until next load completes.
- Misalign  out  1  alignment-fault pulse (see Optional Feature).
- mem_addr  out  MEM_AW  word address = Address[MEM_AW+1:2].
- mem_re  out  1  read strobe; mem_rdata is valid the cycle after.
- mem_we  out  1  write strobe; full 32-bit word write.
- mem_wdata  out  32  write word.
- mem_rdata  in  32  read data from memory.

Behaviour:
- Reset values: state IDLE; mem_re, mem_we, Done, Misalign = 0; mem_addr, mem_wdata, ReadData = 0.
- Reset asserted mid-operation aborts immediately: strobes drop asynchronously and no partial write is issued afterwards.
- Outputs mem_*, Done and Misalign are registered. Stall is combinational.
- Stall = (state==IDLE && (MemRead||MemWrite)) || (state!=IDLE && state!=DONE).
- The pipeline holds all inputs stable while Stall=1.
- Request priority: MemWrite wins if both MemWrite and MemRead are set; MemRead is then ignored.
- The request is latched on the IDLE cycle it is seen: address, size, data and kind.
- State machine (states IDLE, WRITE, READ, WAIT, MERGE, DONE):
  - IDLE: word store -> WRITE; sub-word store or any load -> READ; otherwise stay.
  - WRITE: mem_we=1 for exactly one cycle, mem_wdata=latched data -> DONE.
  - READ: mem_re=1 for one cycle -> WAIT.
  - WAIT: capture mem_rdata. Load -> DONE, with ReadData set from the captured word. Store -> MERGE.
  - MERGE: mem_we=1, mem_wdata = captured word with the selected lanes replaced -> DONE.
  - DONE: Done=1, Stall=0 -> IDLE unconditionally; the new instruction is sampled in IDLE.
- Latency from request cycle to Done: word store 2 cycles; load 3; sub-word store 4.
- Lane rules (little-endian):
  - Byte lane = Address[1:0].
  - Half lane = Address[1].
  - Store byte replaces bits [8k+7:8k] with WriteData[7:0].
  - Store half replaces [16k+15:16k] with WriteData[15:0].
  - Load byte/half is sign-extended to 32 bits.
  - Address bits above MEM_AW+1 are ignored (wrap-around).

Optional Feature:
- Macro MEM_MISALIGN_TRAP_EN.
- Defined: in IDLE, a half access with Address[0]=1 or a word access with Address[1:0]!=0 skips memory and goes straight to DONE, with Misalign=1 for that cycle. No strobes are issued, ReadData is unchanged, and latency is 1 cycle.
- Undefined: Misalign is tied 0. Word accesses ignore Address[1:0]; half accesses ignore Address[0].

Decomposition:
- Shared package:
  - Size encodings SIZE_WORD=2'b00, SIZE_HALF=2'b01, SIZE_BYTE=2'b10.
  - The sequencer state enum.
  - The opcode constants used by the controller (LW/LH/LB/SW/SH/SB).
- One combinational sub-module, mem_lane_merge: inputs word, data, size, lane; outputs merged store word and sign-extended load value.

Test Plan:
- SW: Address=0x0000_0008, WriteData=0xDEADBEEF -> mem_we one cycle at mem_addr=2 with 0xDEADBEEF; Done 2 cycles after request; Stall high exactly 2 cycles.
- SB: mem[2]=0x11223344, Address=0x0000_000A, WriteData=0x000000AA -> read, then write 0x11AA3344; Done on cycle 4.
- LH: mem[2]=0x8001_7FFF, Address=0x0000_000A -> ReadData=0xFFFF8001 with Done on cycle 3; Address=0x8 -> 0x00007FFF.
- LB sign-extension: mem[0]=0x0000_0080, Address=0 -> ReadData=0xFFFFFF80.
- Rst pulsed during MERGE of an SH -> mem_we drops immediately, memory word unchanged, state IDLE, Stall=0 with no request.
- MEM_MISALIGN_TRAP_EN: LW Address=0x0000_0006 -> Misalign=1 and Done=1 next cycle, no mem_re/mem_we; without macro -> normal word read of mem[1].
